// File: rtl/mem_arbiter_pkg.sv
// Shared constants, state encoding and index helper for the memory arbiter
// and the round-robin picker.
package mem_arbiter_pkg;

   localparam int unsigned MEM_ADDR_W = 6;
   localparam int unsigned MEM_DATA_W = 16;
   localparam int unsigned IDX_W      = 3;
   localparam int unsigned REQ_CPU    = 0;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   // (idx + 1) mod n, for idx < n
   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                 input int unsigned n);
      if (32'(idx) + 32'd1 >= n) return '0;
      else                       return idx + IDX_W'(1);
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first candidate at or after i_ptr,
// wrapping, with an exclusion mask. Reusable by other bus arbiters.
module rr_picker
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   input  logic [NUM_REQ-1:0] i_excl,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_valid
);

   logic [NUM_REQ-1:0] w_cand;
   logic [NUM_REQ-1:0] w_hi;
   logic [NUM_REQ-1:0] w_sel;

   assign w_cand = i_req & ~i_excl;

   // Candidates at/above the pointer take priority; otherwise wrap to the lowest.
   always_comb begin
      w_hi = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_hi[i] = w_cand[i] && (IDX_W'(i) >= i_ptr);
      end
      w_sel   = (|w_hi) ? w_hi : w_cand;
      o_valid = |w_cand;
      o_idx   = '0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (w_sel[i]) o_idx = IDX_W'(i);
      end
      o_onehot = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         o_onehot[i] = o_valid && (o_idx == IDX_W'(i));
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between
// NUM_REQ requesters, with a bounded lock for read-modify-write sequences.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = MEM_ADDR_W,
   parameter int unsigned DATA_WIDTH = MEM_DATA_W,
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned LOCK_MAX   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            lock,
   input  logic [NUM_REQ-1:0]            we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            rvalid,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic                          mem_we,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_data,
   input  logic [DATA_WIDTH-1:0]         mem_in,
   output logic [IDX_W-1:0]              owner,
   output logic                          locked
);

   localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

   arb_state_t          r_state,  w_state_nxt;
   logic [IDX_W-1:0]    r_ptr,    w_ptr_nxt;
   logic [IDX_W-1:0]    r_owner,  w_owner_nxt;
   logic [CNT_W-1:0]    r_cnt,    w_cnt_nxt;
   logic [NUM_REQ-1:0]  r_excl,   w_excl_nxt;
   logic [NUM_REQ-1:0]  r_rvalid;
   logic [NUM_REQ-1:0]  w_gnt;
   logic [NUM_REQ-1:0]  w_owner_oh;
   logic [NUM_REQ-1:0]  w_pick_oh;
   logic [IDX_W-1:0]    w_pick_idx;
   logic                w_pick_vld;
   logic                w_lock_own;
   logic                w_others;
   logic                w_mem_we;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [DATA_WIDTH-1:0] w_mem_data;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .i_excl   (r_excl),
      .o_onehot (w_pick_oh),
      .o_idx    (w_pick_idx),
      .o_valid  (w_pick_vld)
   );

   always_comb begin
      w_owner_oh = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_owner_oh[i] = (r_owner == IDX_W'(i));
      end
   end

   assign w_lock_own = |(lock & w_owner_oh);
   assign w_others   = |(req & ~w_owner_oh);

   // Next-state and grant
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_cnt;
      w_excl_nxt  = r_excl;
      w_gnt       = '0;
      case (r_state)
         ST_IDLE: begin
            w_excl_nxt = '0;
            w_gnt      = w_pick_oh;
            if (w_pick_vld) begin
               w_owner_nxt = w_pick_idx;
               w_ptr_nxt   = wrap_inc(w_pick_idx, NUM_REQ);
               if (|(lock & w_pick_oh)) begin
                  w_state_nxt = ST_LOCKED;
                  w_cnt_nxt   = CNT_W'(1);
               end
            end
         end
         ST_LOCKED: begin
            w_gnt = req & w_owner_oh;
            if (!w_lock_own) begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = wrap_inc(r_owner, NUM_REQ);
               w_cnt_nxt   = '0;
            end else if ((r_cnt >= CNT_W'(LOCK_MAX)) && w_others) begin
               // Forced release: owner sits out the next arbitration round
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = wrap_inc(r_owner, NUM_REQ);
               w_cnt_nxt   = '0;
               w_excl_nxt  = w_owner_oh;
            end else if (r_cnt < CNT_W'(LOCK_MAX)) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (rst) w_gnt = '0;
   end

   // Memory port mux from the one-hot grant; all zero when nobody wins
   always_comb begin
      w_mem_we   = |(w_gnt & we);
      w_mem_addr = '0;
      w_mem_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) begin
            w_mem_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_mem_data = wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_ptr    <= '0;
         r_owner  <= '0;
         r_cnt    <= '0;
         r_excl   <= '0;
         r_rvalid <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_ptr    <= w_ptr_nxt;
         r_owner  <= w_owner_nxt;
         r_cnt    <= w_cnt_nxt;
         r_excl   <= w_excl_nxt;
         r_rvalid <= w_gnt & ~we;
      end
   end

   assign gnt      = w_gnt;
   assign mem_we   = w_mem_we;
   assign mem_addr = w_mem_addr;
   assign mem_data = w_mem_data;
   assign rdata    = mem_in;
   assign owner    = r_owner;
   // Reset kills an in-flight read pulse and the lock indication immediately
   assign rvalid   = r_rvalid & {NUM_REQ{~rst}};
   assign locked   = (r_state == ST_LOCKED) && !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for single-cycle behaviour,
// hand-written sequences for lock expiry, exclusion and reset corner cases.
module tb_mem_arbiter;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 16;
   localparam int unsigned NR = 2;
   localparam int unsigned LM = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req, lock, we;
   logic [NR*AW-1:0]  addr;
   logic [NR*DW-1:0]  wdata;
   logic [NR-1:0]     gnt, rvalid;
   logic [DW-1:0]     rdata, mem_data, mem_in;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [2:0]        owner;
   logic              locked;
   logic [DW-1:0]     mem [64];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .LOCK_MAX(LM)) u_dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_in(mem_in), .owner(owner), .locked(locked)
   );

   // Single-port synchronous memory, one-cycle read latency
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_data;
      mem_in <= mem[mem_addr];
   end

   typedef struct {
      logic        rst;
      logic [1:0]  req, lock, we;
      logic [5:0]  a0, a1;
      logic [15:0] d0, d1;
      logic [1:0]  e_gnt;
      logic        e_we;
      logic [5:0]  e_addr;
      logic [15:0] e_data;
      logic [1:0]  e_rv;
      logic [15:0] e_rdata;
      logic        e_lk;
      logic [2:0]  e_own;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [1:0] rq, input logic [1:0] lk,
                       input logic [1:0] w, input logic [5:0] a0, input logic [5:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1);
      @(posedge clk);
      #1;
      rst = r; req = rq; lock = lk; we = w;
      addr = {a1, a0}; wdata = {d1, d0};
      #2;
   endtask

   // Reset, acquire lock for requester 0 with requester 1 waiting, then n locked cycles
   task automatic lock_run(input string tag, input int n, input logic last_lock);
      step(1'b1, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
      step(1'b0, 2'b11, 2'b01, 2'b00, 6'd1, 6'd2, 16'h0, 16'h0);
      chk({tag, " acquire gnt"}, 32'(gnt), 32'b01);
      chk({tag, " acquire locked"}, 32'(locked), 32'b0);
      for (int k = 1; k <= n; k++) begin
         step(1'b0, 2'b11, (k == n && !last_lock) ? 2'b00 : 2'b01, 2'b00,
              6'd1, 6'd2, 16'h0, 16'h0);
         chk($sformatf("%s locked%0d gnt", tag, k), 32'(gnt), 32'b01);
         chk($sformatf("%s locked%0d locked", tag, k), 32'(locked), 32'b1);
      end
   endtask

   initial begin
      rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[3] = 16'h0055; mem[8] = 16'h1234; mem[10] = 16'h00A0; mem[20] = 16'h0B00;

      //          rst   req    lock   we     a0     a1     d0        d1        gnt    we    addr   data      rv     rdata     lk    own
      tbl[0]  = '{1'b0, 2'b01, 2'b00, 2'b00, 6'd8,  6'd0,  16'h0,    16'h0,    2'b01, 1'b0, 6'd8,  16'h0,    2'b00, 16'h0,    1'b0, 3'd0};
      tbl[1]  = '{1'b0, 2'b00, 2'b00, 2'b00, 6'd8,  6'd0,  16'h0,    16'h0,    2'b00, 1'b0, 6'd0,  16'h0,    2'b01, 16'h1234, 1'b0, 3'd0};
      tbl[2]  = '{1'b1, 2'b11, 2'b00, 2'b00, 6'd10, 6'd20, 16'h0,    16'h0,    2'b00, 1'b0, 6'd0,  16'h0,    2'b00, 16'h0,    1'b0, 3'd0};
      tbl[3]  = '{1'b0, 2'b11, 2'b00, 2'b00, 6'd10, 6'd20, 16'h0,    16'h0,    2'b01, 1'b0, 6'd10, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0};
      tbl[4]  = '{1'b0, 2'b11, 2'b00, 2'b00, 6'd10, 6'd20, 16'h0,    16'h0,    2'b10, 1'b0, 6'd20, 16'h0,    2'b01, 16'h00A0, 1'b0, 3'd0};
      tbl[5]  = '{1'b0, 2'b11, 2'b00, 2'b00, 6'd10, 6'd20, 16'h0,    16'h0,    2'b01, 1'b0, 6'd10, 16'h0,    2'b10, 16'h0B00, 1'b0, 3'd1};
      tbl[6]  = '{1'b0, 2'b11, 2'b00, 2'b00, 6'd10, 6'd20, 16'h0,    16'h0,    2'b10, 1'b0, 6'd20, 16'h0,    2'b01, 16'h00A0, 1'b0, 3'd0};
      tbl[7]  = '{1'b0, 2'b10, 2'b00, 2'b10, 6'd10, 6'd5,  16'h0,    16'hBEEF, 2'b10, 1'b1, 6'd5,  16'hBEEF, 2'b10, 16'h0B00, 1'b0, 3'd1};
      tbl[8]  = '{1'b0, 2'b00, 2'b00, 2'b00, 6'd0,  6'd0,  16'h0,    16'h0,    2'b00, 1'b0, 6'd0,  16'h0,    2'b00, 16'h0,    1'b0, 3'd1};
      tbl[9]  = '{1'b0, 2'b01, 2'b00, 2'b00, 6'd5,  6'd0,  16'h0,    16'h0,    2'b01, 1'b0, 6'd5,  16'h0,    2'b00, 16'h0,    1'b0, 3'd1};
      tbl[10] = '{1'b0, 2'b10, 2'b00, 2'b00, 6'd5,  6'd3,  16'h0,    16'h0,    2'b10, 1'b0, 6'd3,  16'h0,    2'b01, 16'hBEEF, 1'b0, 3'd0};
      tbl[11] = '{1'b0, 2'b11, 2'b01, 2'b00, 6'd3,  6'd20, 16'h0,    16'h0,    2'b01, 1'b0, 6'd3,  16'h0,    2'b10, 16'h0055, 1'b0, 3'd1};
      tbl[12] = '{1'b0, 2'b11, 2'b00, 2'b01, 6'd3,  6'd20, 16'h0056, 16'h0,    2'b01, 1'b1, 6'd3,  16'h0056, 2'b01, 16'h0055, 1'b1, 3'd0};
      tbl[13] = '{1'b0, 2'b10, 2'b00, 2'b00, 6'd3,  6'd20, 16'h0,    16'h0,    2'b10, 1'b0, 6'd20, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0};
      tbl[14] = '{1'b0, 2'b01, 2'b00, 2'b00, 6'd3,  6'd20, 16'h0,    16'h0,    2'b01, 1'b0, 6'd3,  16'h0,    2'b10, 16'h0B00, 1'b0, 3'd1};
      tbl[15] = '{1'b0, 2'b00, 2'b00, 2'b00, 6'd3,  6'd20, 16'h0,    16'h0,    2'b00, 1'b0, 6'd0,  16'h0,    2'b01, 16'h0056, 1'b0, 3'd0};

      step(1'b1, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
      for (int i = 0; i < 16; i++) begin
         step(tbl[i].rst, tbl[i].req, tbl[i].lock, tbl[i].we, tbl[i].a0, tbl[i].a1,
              tbl[i].d0, tbl[i].d1);
         chk($sformatf("row%0d gnt", i),      32'(gnt),      32'(tbl[i].e_gnt));
         chk($sformatf("row%0d mem_we", i),   32'(mem_we),   32'(tbl[i].e_we));
         chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
         chk($sformatf("row%0d mem_data", i), 32'(mem_data), 32'(tbl[i].e_data));
         chk($sformatf("row%0d rvalid", i),   32'(rvalid),   32'(tbl[i].e_rv));
         chk($sformatf("row%0d locked", i),   32'(locked),   32'(tbl[i].e_lk));
         chk($sformatf("row%0d owner", i),    32'(owner),    32'(tbl[i].e_own));
         if (tbl[i].e_rv != 2'b00)
            chk($sformatf("row%0d rdata", i), 32'(rdata), 32'(tbl[i].e_rdata));
      end

      // Lock expiry with requester 1 waiting, then re-acquire and saturation
      lock_run("expiry", LM, 1'b1);
      step(1'b0, 2'b11, 2'b01, 2'b00, 6'd1, 6'd2, 16'h0, 16'h0);
      chk("expiry handoff gnt", 32'(gnt), 32'b10);
      chk("expiry handoff locked", 32'(locked), 32'b0);
      chk("expiry handoff owner", 32'(owner), 32'd0);
      step(1'b0, 2'b11, 2'b01, 2'b00, 6'd1, 6'd2, 16'h0, 16'h0);
      chk("reacquire gnt", 32'(gnt), 32'b01);
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 2'b01, 2'b01, 2'b00, 6'd1, 6'd2, 16'h0, 16'h0);
         chk($sformatf("saturate%0d gnt", k), 32'(gnt), 32'b01);
         chk($sformatf("saturate%0d locked", k), 32'(locked), 32'b1);
      end
      step(1'b0, 2'b11, 2'b01, 2'b00, 6'd1, 6'd2, 16'h0, 16'h0);
      chk("saturated waiter gnt", 32'(gnt), 32'b01);
      step(1'b0, 2'b11, 2'b01, 2'b00, 6'd1, 6'd2, 16'h0, 16'h0);
      chk("saturated handoff gnt", 32'(gnt), 32'b10);
      chk("saturated handoff locked", 32'(locked), 32'b0);

      // Forced release excludes the old owner for one arbitration cycle
      lock_run("exclude", LM, 1'b1);
      step(1'b0, 2'b01, 2'b00, 2'b00, 6'd1, 6'd2, 16'h0, 16'h0);
      chk("exclude gnt", 32'(gnt), 32'b00);
      step(1'b0, 2'b01, 2'b00, 2'b00, 6'd1, 6'd2, 16'h0, 16'h0);
      chk("exclude after gnt", 32'(gnt), 32'b01);

      // Lock drop coinciding with expiry is a normal release
      lock_run("drop", LM, 1'b0);
      step(1'b0, 2'b01, 2'b00, 2'b00, 6'd1, 6'd2, 16'h0, 16'h0);
      chk("drop no-exclude gnt", 32'(gnt), 32'b01);

      // Reset while locked with a read in flight
      step(1'b1, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
      step(1'b0, 2'b01, 2'b01, 2'b00, 6'd8, 6'd2, 16'h0, 16'h0);
      chk("rstlk acquire gnt", 32'(gnt), 32'b01);
      step(1'b0, 2'b01, 2'b01, 2'b00, 6'd8, 6'd2, 16'h0, 16'h0);
      chk("rstlk locked", 32'(locked), 32'b1);
      chk("rstlk rvalid", 32'(rvalid), 32'b01);
      chk("rstlk rdata", 32'(rdata), 32'h1234);
      step(1'b1, 2'b11, 2'b01, 2'b01, 6'd8, 6'd2, 16'h0, 16'h0);
      chk("in-reset gnt", 32'(gnt), 32'b00);
      chk("in-reset mem_we", 32'(mem_we), 32'b0);
      chk("in-reset rvalid", 32'(rvalid), 32'b00);
      chk("in-reset locked", 32'(locked), 32'b0);
      step(1'b0, 2'b11, 2'b00, 2'b00, 6'd8, 6'd2, 16'h0, 16'h0);
      chk("post-reset gnt", 32'(gnt), 32'b01);
      chk("post-reset rvalid", 32'(rvalid), 32'b00);
      chk("post-reset locked", 32'(locked), 32'b0);
      chk("post-reset owner", 32'(owner), 32'd0);
      step(1'b0, 2'b11, 2'b00, 2'b00, 6'd8, 6'd2, 16'h0, 16'h0);
      chk("post-reset rr gnt", 32'(gnt), 32'b10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
